div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Reset is rst, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
REQ-005 opdata1_i  input  32  dividend; sampled at start.
REQ-006 opdata2_i  input  32  divisor; sampled at start.
REQ-007 start_i  input  1  request from EX; held high by EX until ready_o is seen.
REQ-008 annul_i  input  1  cancel the current division (pipeline flush).
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  result_o is valid.
REQ-011 busy_o  output  1  division in progress; EX drives stallreq from it.

Function
REQ-012 The FSM SHALL have 4 states: FREE, BYZERO, ON, END.
REQ-013 In FREE with start_i=1 and annul_i=0, the FSM SHALL latch the operands and sign mode, then go to BYZERO if divisor==0, else to ON with cnt=0.
REQ-014 On entry to ON, the working register SHALL be 65 bits, loaded with {32'b0, |op1|, 1'b0}; divisor register = |op2|; absolute values apply only when signed_div_i=1.
REQ-015 Each ON cycle with cnt<32 SHALL compute diff = {1'b0, work[63:32]} - {1'b0, divisor}.
REQ-016 If diff[32]=1, work SHALL become {work[63:0], 1'b0}; otherwise work SHALL become {diff[31:0], work[31:0], 1'b1}; cnt SHALL then increment.
REQ-017 In ON with cnt==32, quotient = work[31:0] and remainder = work[64:33].
REQ-018 In that same cycle, the quotient SHALL be negated if signed and op1[31]^op2[31], the remainder SHALL be negated if signed and op1[31], and the FSM SHALL go to END.
REQ-019 BYZERO SHALL go to END after one cycle with result = 64'h0.
REQ-020 In END, ready_o=1 and result_o SHALL hold the final value stably.
REQ-021 END SHALL go to FREE when start_i=0; ready_o and result_o SHALL be 0 from that edge.
REQ-022 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with ready_o=0 and no result produced.
REQ-023 annul_i SHALL have no effect in FREE or END.
REQ-024 Latency: ready_o SHALL rise after 34 clock edges for a nonzero divisor and after 2 edges for a zero divisor, counted from the edge that samples start_i in FREE.
REQ-025 busy_o SHALL be 1 in BYZERO and ON, and 0 in FREE and END.
REQ-026 Operand changes after the start edge SHALL be ignored.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-028 Arithmetic is modulo 2^32; no overflow flag.

Reset
REQ-029 On rst=1 at a clock edge: state=FREE; ready_o=0; busy_o=0; result_o=64'h0; cnt=0; working registers = 0.
REQ-030 Reset SHALL take priority over annul_i and start_i, including during ON.

Structure
REQ-031 State encodings (DivFree, DivByZero, DivOn, DivEnd, 2 bits), DivResultReady/NotReady, DivStart/Stop and 64-bit DoubleRegBus width SHALL live in defines.v.
REQ-032 No sub-module: one FSM process plus a combinational subtract.
REQ-033 The EX stage instantiates div_seq and owns the HI/LO write of result_o.

Verification
REQ-034 Unsigned 100/7, start held: ready_o rises at edge 34; result_o = 64'h00000002_0000000E; busy_o=1 for edges 1-33.
REQ-035 Signed -7/2 (0xFFFFFFF9/0x2): result_o = 64'hFFFFFFFF_FFFFFFFD.
REQ-036 Divide by zero (0x1234/0): ready_o rises at edge 2; result_o = 64'h0.
REQ-037 annul_i pulsed at edge 10 of ON: state FREE at edge 11; ready_o never rises; a following 9/3 start gives 64'h00000000_00000003.
REQ-038 start_i held 3 cycles in END: ready_o and result_o stay stable; start_i dropped -> ready_o=0 and result_o=0 next edge.
REQ-039 rst asserted at edge 20 of ON: all outputs 0 and state FREE next edge; a new start then completes normally.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared encodings and helpers for the sequential 32-bit divider.
// State codes and result/start constants mirror the EX stage's existing defines.
package div_seq_pkg;

    localparam int DOUBLE_REG_W = 64;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of v when signed mode is active, v unchanged otherwise.
    function automatic logic [31:0] abs_if_signed(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'h0000_0000 - v) : v;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake bundle.
// slave is the divider side, master is the EX stage side.
interface div_seq_if;
    import div_seq_pkg::*;

    logic                    signed_div_i;
    logic [31:0]             opdata1_i;
    logic [31:0]             opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DOUBLE_REG_W-1:0] result_o;
    logic                    ready_o;
    logic                    busy_o;

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider: 32 iterations, signed/unsigned, result {rem, quot}.
// Result and ready are registered and held in END until the EX stage drops start.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    div_seq_if.slave    div_bus
);

    div_state_e              state_q, state_d;
    logic [64:0]             work_q, work_d;
    logic [31:0]             divisor_q, divisor_d;
    logic [5:0]              cnt_q, cnt_d;
    logic                    signed_q, signed_d;
    logic                    op1_neg_q, op1_neg_d;
    logic                    op2_neg_q, op2_neg_d;
    logic [DOUBLE_REG_W-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [32:0] diff_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] op1_abs_s;
    logic [31:0] op2_abs_s;

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            work_q    <= 65'h0;
            divisor_q <= 32'h0;
            cnt_q     <= 6'd0;
            signed_q  <= 1'b0;
            op1_neg_q <= 1'b0;
            op2_neg_q <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            op1_neg_q <= op1_neg_d;
            op2_neg_q <= op2_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Trial subtract, operand magnitudes and sign-corrected final quotient/remainder.
    always_comb begin
        diff_s    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        op1_abs_s = abs_if_signed(div_bus.opdata1_i, div_bus.signed_div_i);
        op2_abs_s = abs_if_signed(div_bus.opdata2_i, div_bus.signed_div_i);
        quot_s    = (signed_q && (op1_neg_q ^ op2_neg_q)) ? (32'h0 - work_q[31:0]) : work_q[31:0];
        rem_s     = (signed_q && op1_neg_q) ? (32'h0 - work_q[64:33]) : work_q[64:33];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        op1_neg_d = op1_neg_q;
        op2_neg_d = op2_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            DivFree: begin
                if ((div_bus.start_i == DIV_START) && !div_bus.annul_i) begin
                    signed_d  = div_bus.signed_div_i;
                    op1_neg_d = div_bus.opdata1_i[31];
                    op2_neg_d = div_bus.opdata2_i[31];
                    cnt_d     = 6'd0;
                    work_d    = {32'h0, op1_abs_s, 1'b0};
                    divisor_d = op2_abs_s;
                    if (div_bus.opdata2_i == 32'h0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                    end
                end else begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = 64'h0;
                end
            end
            DivByZero: begin
                if (div_bus.annul_i) begin
                    state_d = DivFree;
                    ready_d = DIV_RESULT_NOT_READY;
                end else begin
                    state_d = DivEnd;
                    ready_d = DIV_RESULT_READY;
                end
                result_d = 64'h0;
            end
            DivOn: begin
                if (div_bus.annul_i) begin
                    state_d  = DivFree;
                    cnt_d    = 6'd0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = 64'h0;
                end else if (cnt_q != 6'd32) begin
                    // A borrow means the divisor did not fit: shift in a 0 quotient bit.
                    if (diff_s[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff_s[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_s, quot_s};
                    ready_d  = DIV_RESULT_READY;
                    cnt_d    = 6'd0;
                    state_d  = DivEnd;
                end
            end
            DivEnd: begin
                if (div_bus.start_i == DIV_STOP) begin
                    state_d  = DivFree;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = 64'h0;
                end else begin
                    state_d = DivEnd;
                end
            end
            default: begin
                state_d  = DivFree;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = 64'h0;
            end
        endcase
    end

    // Outputs are straight register decodes.
    always_comb begin
        div_bus.busy_o   = (state_q == DivOn) || (state_q == DivByZero);
        div_bus.ready_o  = ready_q;
        div_bus.result_o = result_q;
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by zero,
// annul, hold-in-END, and reset during an active division.
module tb_div_seq;

    logic clk;
    logic rst;
    int   checks_n;
    int   fails_n;

    div_seq_if bus ();

    div_seq dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_n++;
        if (obs !== exp) begin
            fails_n++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a division with start held, checks latency/busy/result, holds 3 cycles
    // in END (annul pulsed in the middle), then drops start.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int edges;
        int busy_gaps;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        edges     = 0;
        busy_gaps = 0;
        do begin
            step();
            edges++;
            bus.opdata1_i    = 32'hDEAD_BEEF;
            bus.opdata2_i    = 32'h0000_0000;
            bus.signed_div_i = ~sgn;
            if (!bus.ready_o && !bus.busy_o) busy_gaps++;
        end while (!bus.ready_o && edges < 200);
        check_eq({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check_eq({tag, " busy"}, 64'(busy_gaps), 64'd0);
        check_eq({tag, " result"}, bus.result_o, exp_res);
        check_eq({tag, " busy_end"}, 64'(bus.busy_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus.annul_i = (i == 1);
            step();
            check_eq({tag, " hold_ready"}, 64'(bus.ready_o), 64'd1);
            check_eq({tag, " hold_result"}, bus.result_o, exp_res);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        step();
        check_eq({tag, " drop_ready"}, 64'(bus.ready_o), 64'd0);
        check_eq({tag, " drop_result"}, bus.result_o, 64'h0);
    endtask

    initial begin
        int rises;
        checks_n = 0;
        fails_n  = 0;
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        step();
        step();
        check_eq("rst ready", 64'(bus.ready_o), 64'd0);
        check_eq("rst busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst result", bus.result_o, 64'h0);
        rst = 1'b0;
        step();

        do_div("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 34);
        do_div("u0xFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'h2, 64'h00000001_7FFFFFFC, 34);
        do_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34);
        do_div("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34);
        do_div("uFFFFFFFF/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34);
        do_div("div0", 1'b0, 32'h1234, 32'h0, 64'h0, 2);

        // Annul in the middle of ON.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("annul pre busy", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        check_eq("annul busy", 64'(bus.busy_o), 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o) rises++;
            step();
        end
        check_eq("annul no_ready", 64'(rises), 64'd0);
        do_div("u9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        // Annul in BYZERO.
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b1;
        step();
        check_eq("bz busy", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        check_eq("bz annul busy", 64'(bus.busy_o), 64'd0);
        check_eq("bz annul ready", 64'(bus.ready_o), 64'd0);
        step();
        check_eq("bz annul ready2", 64'(bus.ready_o), 64'd0);

        // Reset during ON.
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        check_eq("rst_on busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_on ready", 64'(bus.ready_o), 64'd0);
        check_eq("rst_on result", bus.result_o, 64'h0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        step();
        do_div("post_rst100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
